ula_escalonador: RTL and testbench

- Arbiter and sequencer that shares the single 8-bit ULA (add / negate / subtract / sign-of-difference) between N_REQ requesters, e.g. PC incrementer and execute stage.
- Grants one requester at a time and latches its operands and ALUOp into registers that drive the ULA.
- Captures Resultado/Zero and returns them with a one-cycle Feito pulse.
- Sits between the control unit / datapath stages and the ULA instance.

---
 rtl/ula_pkg.sv | 12 +
 rtl/arbitro_rr.sv | 56 +++++
 rtl/ula_escalonador.sv | 71 +++++++
 tb/tb_ula_escalonador.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: ULA width, ALUOp codes, scheduler state type and a modulo-increment helper.
package ula_pkg;
    localparam int LARGURA = 8;
    localparam logic [1:0] ULA_SOMA  = 2'b00;
    localparam logic [1:0] ULA_NEGA  = 2'b01;
    localparam logic [1:0] ULA_SUB   = 2'b10;
    localparam logic [1:0] ULA_MENOR = 2'b11;
    typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;
    function automatic int prox(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr: one-hot winner among unmasked requests, round-robin from ptr by default;
// ULA_ESCALONADOR_PRIO_FIXA_EN selects fixed priority (lowest index wins, no pointer).
module arbitro_rr import ula_pkg::*; #(
    parameter int N_REQ = 2,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             update,
    output logic [N_REQ-1:0] venc,
    output logic [IW-1:0]    idx,
    output logic             tem
);
    logic [N_REQ-1:0] cand;
    assign cand = req & ~mask;
`ifdef ULA_ESCALONADOR_PRIO_FIXA_EN
    always_comb begin
        venc = '0;
        idx = '0;
        tem = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!tem && cand[i]) begin
                tem = 1'b1;
                idx = IW'(i);
                venc[i] = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    int j;
    // Search starts at ptr and wraps, so the last winner goes to the back of the line.
    always_comb begin
        venc = '0;
        idx = '0;
        tem = 1'b0;
        j = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!tem && cand[j]) begin
                tem = 1'b1;
                idx = IW'(j);
                venc[j] = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (update && tem)
            ptr <= IW'(prox(int'(idx), N_REQ));
    end
`endif
endmodule

// File: rtl/ula_escalonador.sv
// ula_escalonador: shares one ULA among N_REQ requesters; grant, latch operands, return result with a Feito pulse.
// Arbitration mode is chosen in arbitro_rr via ULA_ESCALONADOR_PRIO_FIXA_EN.
module ula_escalonador #(
    parameter int N_REQ = 2,
    parameter int LARGURA = ula_pkg::LARGURA
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ*LARGURA-1:0] OperandoA,
    input  logic [N_REQ*LARGURA-1:0] OperandoB,
    input  logic [N_REQ*2-1:0]       Op,
    output logic [N_REQ-1:0]         Gnt,
    output logic [N_REQ-1:0]         Feito,
    output logic [LARGURA-1:0]       ResultadoOut,
    output logic                     ZeroOut,
    output logic                     Ocupado,
    output logic [LARGURA-1:0]       UlaEntrada1,
    output logic [LARGURA-1:0]       UlaEntrada2,
    output logic [1:0]               UlaALUOp,
    input  logic [LARGURA-1:0]       UlaResultado,
    input  logic                     UlaZero
);
    import ula_pkg::*;
    localparam int IW = $clog2(N_REQ);
    estado_t estado;
    logic [N_REQ-1:0] venc;
    logic [N_REQ-1:0] mask;
    logic [IW-1:0] idx;
    logic tem;
    // The served requester still holds Req during RESPONDE, so it must not win again.
    assign mask = (estado == RESPONDE) ? Gnt : '0;
    arbitro_rr #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .clk(Clock),
        .rst(Reset),
        .req(Req),
        .mask(mask),
        .update(estado != EXECUTA),
        .venc(venc),
        .idx(idx),
        .tem(tem)
    );
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado <= OCIOSO;
            Gnt <= '0;
            Feito <= '0;
            ResultadoOut <= '0;
            ZeroOut <= 1'b0;
            Ocupado <= 1'b0;
            UlaEntrada1 <= '0;
            UlaEntrada2 <= '0;
            UlaALUOp <= '0;
        end else if (estado == EXECUTA) begin
            ResultadoOut <= UlaResultado;
            ZeroOut <= UlaZero;
            Feito <= Gnt;
            estado <= RESPONDE;
        end else begin
            Feito <= '0;
            Gnt <= venc;
            Ocupado <= tem;
            estado <= tem ? EXECUTA : OCIOSO;
            if (tem) begin
                UlaEntrada1 <= OperandoA[idx*LARGURA +: LARGURA];
                UlaEntrada2 <= OperandoB[idx*LARGURA +: LARGURA];
                UlaALUOp <= Op[idx*2 +: 2];
            end
        end
    end
endmodule

// File: tb/tb_ula_escalonador.sv
// tb_ula_escalonador: randomized requesters and a transaction-level reference model, plus literal checks.
module tb_ula_escalonador;
    localparam int N = 2;
    localparam int W = 8;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic [N-1:0] Req = '1;
    logic [N*W-1:0] OperandoA = '0;
    logic [N*W-1:0] OperandoB = '0;
    logic [N*2-1:0] Op = '0;
    logic [N-1:0] Gnt, Feito;
    logic [W-1:0] ResultadoOut, UlaEntrada1, UlaEntrada2, UlaResultado;
    logic ZeroOut, Ocupado, UlaZero;
    logic [1:0] UlaALUOp;
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    function automatic logic [W-1:0] ula_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        logic [W-1:0] d;
        d = a - b;
        case (op)
            2'b00: return a + b;
            2'b01: return W'(0) - a;
            2'b10: return d;
            default: return {W{d[W-1]}};
        endcase
    endfunction

    assign UlaResultado = ula_ref(UlaEntrada1, UlaEntrada2, UlaALUOp);
    assign UlaZero = (UlaResultado == '0);

    ula_escalonador #(.N_REQ(N), .LARGURA(W)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req),
        .OperandoA(OperandoA), .OperandoB(OperandoB), .Op(Op),
        .Gnt(Gnt), .Feito(Feito), .ResultadoOut(ResultadoOut), .ZeroOut(ZeroOut),
        .Ocupado(Ocupado), .UlaEntrada1(UlaEntrada1), .UlaEntrada2(UlaEntrada2),
        .UlaALUOp(UlaALUOp), .UlaResultado(UlaResultado), .UlaZero(UlaZero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who is being served, whether its result is already out, and the fairness pointer.
    int m_srv = -1;
    bit m_done = 1'b0;
    int m_ptr = 0;
    bit m_valid = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0] m_op = '0;
    logic m_zero = 1'b0;
    logic [N-1:0] m_feito = '0;

    function automatic int pick(input logic [N-1:0] r, input int excl, input int p);
        for (int k = 0; k < N; k++) begin
`ifdef ULA_ESCALONADOR_PRIO_FIXA_EN
            int c = k;
`else
            int c = (p + k) % N;
`endif
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    initial forever begin
        int w;
        @(posedge Clock);
        if (Reset) begin
            m_srv = -1; m_done = 1'b0; m_ptr = 0;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 1'b0; m_feito = '0;
        end else begin
            m_feito = '0;
            if (m_srv >= 0 && !m_done) begin
                m_res = ula_ref(m_a, m_b, m_op);
                m_zero = (m_res == '0);
                m_feito[m_srv] = 1'b1;
                m_done = 1'b1;
            end else begin
                w = pick(Req, m_srv, m_ptr);
                m_srv = w;
                m_done = 1'b0;
                if (w >= 0) begin
                    m_a = OperandoA[w*W +: W];
                    m_b = OperandoB[w*W +: W];
                    m_op = Op[w*2 +: 2];
                    m_ptr = (w + 1) % N;
                end
            end
        end
        m_valid = 1'b1;
    end

    initial forever begin
        @(negedge Clock);
        if (m_valid) begin
            chk("gnt", 32'(Gnt), (m_srv >= 0) ? (32'd1 << m_srv) : 32'd0);
            chk("feito", 32'(Feito), 32'(m_feito));
            chk("resultado", 32'(ResultadoOut), 32'(m_res));
            chk("zero", 32'(ZeroOut), 32'(m_zero));
            chk("ocupado", 32'(Ocupado), 32'(m_srv >= 0));
            chk("entrada1", 32'(UlaEntrada1), 32'(m_a));
            chk("entrada2", 32'(UlaEntrada2), 32'(m_b));
            chk("aluop", 32'(UlaALUOp), 32'(m_op));
        end
    end

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        OperandoA[i*W +: W] = a;
        OperandoB[i*W +: W] = b;
        Op[i*2 +: 2] = op;
    endtask

    task automatic serve(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic [W-1:0] er, input logic ez);
        int n = 0;
        @(negedge Clock);
        set_ops(i, a, b, op);
        Req[i] = 1'b1;
        do begin
            @(negedge Clock);
            n++;
        end while (!Feito[i] && n < 20);
        chk("latencia", n, 2);
        chk("lit_resultado", 32'(ResultadoOut), 32'(er));
        chk("lit_zero", 32'(ZeroOut), 32'(ez));
        Req[i] = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        logic [N-1:0] eg;
        int n;
        repeat (2) @(negedge Clock);
        chk("rst_gnt", 32'(Gnt), 0);
        chk("rst_feito", 32'(Feito), 0);
        chk("rst_resultado", 32'(ResultadoOut), 0);
        chk("rst_ocupado", 32'(Ocupado), 0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("primeiro_gnt", 32'(Gnt), 32'h1);
        Req = '0;
        @(negedge Clock);
        chk("feito_apos_queda", 32'(Feito), 32'h1);
        serve(0, 8'd5, 8'd3, 2'b00, 8'd8, 1'b0);
        serve(1, 8'd4, 8'd4, 2'b10, 8'd0, 1'b1);
        serve(0, 8'd1, 8'd0, 2'b01, 8'hFF, 1'b0);
        serve(1, 8'd3, 8'd5, 2'b11, 8'hFF, 1'b0);
        serve(1, 8'd5, 8'd3, 2'b11, 8'h00, 1'b1);
        set_ops(0, 8'd10, 8'd20, 2'b00);
        set_ops(1, 8'd7, 8'd7, 2'b10);
        Req = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            eg = ((k / 2) % 2 != 0) ? 2'b10 : 2'b01;
            chk("disputa_gnt", 32'(Gnt), 32'(eg));
            chk("disputa_feito", 32'(Feito), (k % 2 != 0) ? 32'(eg) : 32'd0);
            chk("disputa_ocupado", 32'(Ocupado), 1);
        end
        Req = '0;
        repeat (2) @(negedge Clock);
        set_ops(0, 8'd9, 8'd7, 2'b10);
        Req[0] = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk("abort_feito", 32'(Feito), 0);
        chk("abort_gnt", 32'(Gnt), 0);
        chk("abort_ocupado", 32'(Ocupado), 0);
        Reset = 1'b0;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!Feito[0] && n < 20);
        chk("reserv_latencia", n, 2);
        chk("reserv_resultado", 32'(ResultadoOut), 32'd2);
        Req = '0;
        repeat (2) @(negedge Clock);
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clock);
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] a;
                a = W'($urandom);
                if (Req[i] && Feito[i])
                    Req[i] = 1'b0;
                else if (!Req[i] && $urandom_range(0, 3) == 0) begin
                    set_ops(i, a, ($urandom_range(0, 3) == 0) ? a : W'($urandom), 2'($urandom));
                    Req[i] = 1'b1;
                end else if (Req[i] && Gnt[i] && $urandom_range(0, 7) == 0)
                    set_ops(i, W'($urandom), W'($urandom), 2'($urandom));
                else if (Req[i] && Gnt[i] && !Feito[i] && $urandom_range(0, 31) == 0)
                    Req[i] = 1'b0;
            end
            Reset = ($urandom_range(0, 199) == 0);
        end
        Reset = 1'b0;
        Req = '0;
        repeat (4) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
